// File: rtl/pac_arm_pkg.sv
// pac_arm_pkg: shared fetch widths and the buffered fetch entry type
package pac_arm_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef struct packed {addr_t pc; word_t instr;} fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry wrap-around FIFO with flush, holding {pc, instr} entries
module fetch_buffer
  import pac_arm_pkg::*;
#(
  parameter int W = $bits(fetch_entry_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic rd_q, wr_q, full;
  logic [1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout = mem_q[rd_q];
  assign full = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
  assign count = cnt_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing sync-read fetches into a 2-entry decode buffer
module instr_fetch_unit #(
  parameter int ADDR_W = pac_arm_pkg::ADDR_W,
  parameter int DATA_W = pac_arm_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] direc,
  input  logic [DATA_W-1:0] dato,
  input  logic              fetch_en,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);
  logic [ADDR_W-1:0] pc_q, pc_d, infl_pc_q;
  logic inflight_q, issue, pop, push, empty;
  logic [1:0] count;
  logic [ADDR_W+DATA_W-1:0] head;
  assign pop = instr_valid & instr_ready;
  assign push = inflight_q & ~redir_valid;
  assign issue = fetch_en & ~redir_valid & ({1'b0, count} + {2'b0, inflight_q} - {2'b0, pop} < 3'd2);
  assign pc_d = redir_valid ? redir_pc : issue ? pc_q + PC_STEP : pc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= issue;
      if (issue) infl_pc_q <= pc_q;
    end
  end
  fetch_buffer #(.W(ADDR_W + DATA_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir_valid),
    .din   ({infl_pc_q, dato}),
    .dout  (head),
    .empty (empty),
    .count (count)
  );
  assign direc = pc_q;
  assign instr_valid = ~empty;
  assign {instr_pc, instr} = head;
endmodule
